board_io_ctrl: RTL and testbench

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

---
 rtl/board_io_ctrl.sv | 124 ++++++++++++
 tb/tb_board_io_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - board switch/pushbutton/LED register block
// Synchronizes switches, debounces buttons into sticky press events, drives LEDs.
module board_io_ctrl #(
  parameter int SW_W      = 18,
  parameter int PB_W      = 4,
  parameter int LEDR_W    = 18,
  parameter int LEDG_W    = 9,
  parameter int DB_CYCLES = 500000
) (
  input  logic              SI_ClkIn,
  input  logic              SI_Reset_N,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [PB_W-1:0]   pb_n_in,
  input  logic [1:0]        addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LEDR_W-1:0] ledr,
  output logic [LEDG_W-1:0] ledg,
  output logic              pb_irq
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [1:0] ADDR_SW  = 2'd0;
  localparam logic [1:0] ADDR_PB  = 2'd1;
  localparam logic [1:0] ADDR_EVT = 2'd2;
  localparam logic [1:0] ADDR_LED = 2'd3;

  logic [SW_W-1:0]          sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [PB_W-1:0]          pb_meta_q, pb_meta_d, pb_sync_q, pb_sync_d;
  logic [PB_W-1:0]          pb_stable_q, pb_stable_d, pb_event_q, pb_event_d;
  logic [PB_W-1:0][CW-1:0]  db_cnt_q, db_cnt_d;
  logic [LEDR_W-1:0]        ledr_q, ledr_d;
  logic [LEDG_W-1:0]        ledg_q, ledg_d;
  logic [31:0]              rdata_q, rdata_d, rd_sel;
  logic                     pb_irq_q, pb_irq_d;
  logic [PB_W-1:0]          pb_rise, ev_clr;
  logic                     unused_wdata;

  assign unused_wdata = ^wdata;

  always_comb begin
    sw_meta_d   = sw_in;
    sw_sync_d   = sw_meta_q;
    pb_meta_d   = ~pb_n_in;
    pb_sync_d   = pb_meta_q;
    pb_stable_d = pb_stable_q;
    db_cnt_d    = db_cnt_q;
    // Counter only runs while the synchronized input disagrees with the stable state.
    for (int i = 0; i < PB_W; i++) begin
      if (pb_sync_q[i] == pb_stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CNT_LAST) begin
        db_cnt_d[i]    = '0;
        pb_stable_d[i] = ~pb_stable_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    pb_rise    = pb_stable_d & ~pb_stable_q;
    ev_clr     = (wr_en && addr == ADDR_EVT) ? wdata[PB_W-1:0] : '0;
    // A press landing on the clearing edge survives the clear.
    pb_event_d = (pb_event_q & ~ev_clr) | pb_rise;
    pb_irq_d   = |pb_event_q;
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    if (wr_en && addr == ADDR_LED) begin
      ledr_d = wdata[LEDR_W-1:0];
      ledg_d = wdata[LEDR_W +: LEDG_W];
    end
  end

  always_comb begin
    rd_sel = '0;
    case (addr)
      ADDR_SW:  rd_sel[SW_W-1:0] = sw_sync_q;
      ADDR_PB:  rd_sel[PB_W-1:0] = pb_stable_q;
      ADDR_EVT: rd_sel[PB_W-1:0] = pb_event_q;
      default: begin
        rd_sel[LEDR_W-1:0]       = ledr_q;
        rd_sel[LEDR_W +: LEDG_W] = ledg_q;
      end
    endcase
    rdata_d = rd_en ? rd_sel : rdata_q;
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      pb_meta_q   <= '0;
      pb_sync_q   <= '0;
      pb_stable_q <= '0;
      pb_event_q  <= '0;
      db_cnt_q    <= '0;
      ledr_q      <= '0;
      ledg_q      <= '0;
      rdata_q     <= '0;
      pb_irq_q    <= 1'b0;
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      pb_meta_q   <= pb_meta_d;
      pb_sync_q   <= pb_sync_d;
      pb_stable_q <= pb_stable_d;
      pb_event_q  <= pb_event_d;
      db_cnt_q    <= db_cnt_d;
      ledr_q      <= ledr_d;
      ledg_q      <= ledg_d;
      rdata_q     <= rdata_d;
      pb_irq_q    <= pb_irq_d;
    end
  end

  assign rdata  = rdata_q;
  assign ledr   = ledr_q;
  assign ledg   = ledg_q;
  assign pb_irq = pb_irq_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - scoreboard bench for board_io_ctrl
// Reference model tracks input history; a negedge monitor pops expected read data.
module tb_board_io_ctrl;
  localparam int SW_W   = 18;
  localparam int PB_W   = 4;
  localparam int LEDR_W = 18;
  localparam int LEDG_W = 9;
  localparam int DB     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SW_W-1:0]   sw_in;
  logic [PB_W-1:0]   pb_n;
  logic [1:0]        addr;
  logic              wr_en, rd_en;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [LEDR_W-1:0] ledr;
  logic [LEDG_W-1:0] ledg;
  logic              pb_irq;

  int checks = 0;
  int failures = 0;

  board_io_ctrl #(
    .SW_W(SW_W), .PB_W(PB_W), .LEDR_W(LEDR_W), .LEDG_W(LEDG_W), .DB_CYCLES(DB)
  ) dut (
    .SI_ClkIn(clk), .SI_Reset_N(rst_n), .sw_in(sw_in), .pb_n_in(pb_n),
    .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
    .rdata(rdata), .ledr(ledr), .ledg(ledg), .pb_irq(pb_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_pbh[k] is the pressed sample taken k+1 edges ago.
  logic [PB_W-1:0]   m_pbh [0:DB];
  logic [SW_W-1:0]   m_swh [0:1];
  logic [PB_W-1:0]   m_stable, m_event, n_stable, m_clr;
  logic [LEDR_W-1:0] m_ledr;
  logic [LEDG_W-1:0] m_ledg;
  logic              m_irq, m_rd_valid;
  logic [31:0]       m_rdval;
  logic [31:0]       exp_q [$];
  bit                all_diff;

  task automatic model_reset();
    for (int k = 0; k <= DB; k++) m_pbh[k] = '0;
    m_swh[0] = '0; m_swh[1] = '0;
    m_stable = '0; m_event = '0; m_ledr = '0; m_ledg = '0;
    m_irq = 1'b0; m_rd_valid = 1'b0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      // A button flips once the delayed input has disagreed for DB consecutive clocks.
      n_stable = m_stable;
      for (int i = 0; i < PB_W; i++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DB; k++) if (m_pbh[k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) n_stable[i] = ~m_stable[i];
      end
      m_rd_valid = rd_en;
      if (rd_en) begin
        case (addr)
          2'd0: m_rdval = 32'(m_swh[1]);
          2'd1: m_rdval = 32'(m_stable);
          2'd2: m_rdval = 32'(m_event);
          default: m_rdval = 32'({m_ledg, m_ledr});
        endcase
        exp_q.push_back(m_rdval);
      end
      m_irq = |m_event;
      m_clr = (wr_en && addr == 2'd2) ? wdata[PB_W-1:0] : '0;
      m_event = (m_event & ~m_clr) | (n_stable & ~m_stable);
      m_stable = n_stable;
      if (wr_en && addr == 2'd3) begin
        m_ledr = wdata[LEDR_W-1:0];
        m_ledg = wdata[LEDR_W +: LEDG_W];
      end
      for (int k = DB; k > 0; k--) m_pbh[k] = m_pbh[k-1];
      m_pbh[0] = ~pb_n;
      m_swh[1] = m_swh[0];
      m_swh[0] = sw_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("pb_irq", 32'(pb_irq), 32'(m_irq));
      check("ledr", 32'(ledr), 32'(m_ledr));
      check("ledg", 32'(ledg), 32'(m_ledg));
      if (m_rd_valid) begin
        if (exp_q.size() == 0) check("rd_queue_underflow", 32'd1, 32'd0);
        else check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input logic [1:0] a);
    addr = a; rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sw_in = '0; pb_n = '1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    step(2);
    check("reset_rdata", rdata, 32'h0);
    check("reset_leds", 32'({ledg, ledr}), 32'h0);
    check("reset_irq", 32'(pb_irq), 32'h0);
    #1 rst_n = 1'b1;
    step(2);

    // Glitch shorter than the debounce window.
    pb_n[0] = 1'b0;
    step(3);
    pb_n[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1);
      check("glitch_irq", 32'(pb_irq), 32'h0);
    end
    do_rd(2'd1); check("glitch_stable", rdata, 32'h0);
    do_rd(2'd2); check("glitch_event", rdata, 32'h0);

    // Held press on button 1.
    pb_n[1] = 1'b0;
    step(5);
    do_rd(2'd2); check("press_event_early", rdata, 32'h0);
    check("press_irq_early", 32'(pb_irq), 32'h0);
    do_rd(2'd2); check("press_event", rdata, 32'h2);
    check("press_irq", 32'(pb_irq), 32'h1);
    do_rd(2'd1); check("press_stable", rdata, 32'h2);

    // Write-1-to-clear.
    pb_n[0] = 1'b0;
    step(8);
    do_rd(2'd2); check("evt_both", rdata, 32'h3);
    do_wr(2'd2, 32'h1);
    check("w1c_irq", 32'(pb_irq), 32'h1);
    do_rd(2'd2); check("w1c_event", rdata, 32'h2);

    // Clear colliding with a fresh press on bit 0.
    pb_n[0] = 1'b1;
    step(8);
    pb_n[0] = 1'b0;
    step(5);
    do_wr(2'd2, 32'h1);
    do_rd(2'd2); check("set_wins", rdata, 32'h3);
    do_wr(2'd2, 32'hFFFF_FFFF);
    step(2);
    check("irq_cleared", 32'(pb_irq), 32'h0);

    // LEDs and read latency.
    do_wr(2'd3, 32'h07FF_FFFF);
    check("ledr_all", 32'(ledr), 32'h3FFFF);
    check("ledg_all", 32'(ledg), 32'h1FF);
    do_rd(2'd3); check("led_read", rdata, 32'h07FF_FFFF);
    addr = 2'd3; wdata = 32'hF123_4567; rd_en = 1'b1; wr_en = 1'b1;
    step(1);
    rd_en = 1'b0; wr_en = 1'b0;
    check("rw_collision_old", rdata, 32'h07FF_FFFF);
    check("ledr_new", 32'(ledr), 32'h34567);
    check("ledg_new", 32'(ledg), 32'h048);
    do_rd(2'd3); check("led_read_new", rdata, 32'h0123_4567);

    // Switch path and read-only registers.
    sw_in = 18'h2A5A5;
    step(2);
    do_rd(2'd0); check("sw_read", rdata, 32'h0002_A5A5);
    do_wr(2'd0, 32'hFFFF_FFFF);
    do_wr(2'd1, 32'hFFFF_FFFF);
    do_rd(2'd0); check("sw_ro", rdata, 32'h0002_A5A5);
    do_rd(2'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      int b;
      b = int'($urandom_range(0, PB_W - 1));
      if ($urandom_range(0, 9) == 0) pb_n[b] = ~pb_n[b];
      sw_in = SW_W'($urandom);
      addr  = 2'($urandom_range(0, 3));
      rd_en = 1'($urandom_range(0, 1));
      wr_en = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      step(1);
    end
    rd_en = 1'b0; wr_en = 1'b0;

    // Asynchronous reset during a debounce with a held button.
    do_wr(2'd3, 32'h0555_5555);
    pb_n = 4'b1011;
    step(3);
    do_rd(2'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rdata", rdata, 32'h0);
    check("async_ledr", 32'(ledr), 32'h0);
    check("async_ledg", 32'(ledg), 32'h0);
    check("async_irq", 32'(pb_irq), 32'h0);
    step(2);
    #1 rst_n = 1'b1;
    step(5);
    do_rd(2'd2); check("post_reset_event_early", rdata, 32'h0);
    check("post_reset_irq_early", 32'(pb_irq), 32'h0);
    do_rd(2'd2); check("post_reset_event", rdata, 32'h4);
    check("post_reset_irq", 32'(pb_irq), 32'h1);

    step(3);
    check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
